regfile_writer: RTL and testbench
=================================

# regfile_writer

Writeback-side driver for the 32-entry decode-stage register file. Merges two producers onto the register file's single write port: the in-order MEM/WB pipeline result, with the final load data formatting done here, and late results from the multi-cycle multiply/divide unit over a valid/ready handshake. Pipeline writes always win. Late results wait in a 2-entry FIFO, and the block raises a stall when that FIFO fills. Sits between the memory stage and the register file; its outputs connect directly to the register file's `write` / `address_dest` / `write_data` pins.

## Interface
- `SIZE`, 32, register file entries; `bits = CLOG2(SIZE)` sets address width
- `DEPTH`, 2, late-result FIFO depth (power of two, ≥2)
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `wb_valid`  in  1  pipeline result present this cycle
- `wb_dest`  in  bits  pipeline destination register
- `wb_mem_to_reg`  in  1  1 = write formatted load data, 0 = write `wb_alu`
- `wb_alu`  in  WORD  ALU result
- `wb_load`  in  WORD  raw memory read word
- `wb_size`  in  2  load size: 00 byte, 01 half, 1x word
- `wb_signed`  in  1  sign-extend a sub-word load
- `wb_offset`  in  2  byte address bits [1:0] of the load
- `late_valid`  in  1  mul/div result offered
- `late_ready`  out  1  FIFO can accept; equals FIFO not full (registered count)
- `late_dest`  in  bits  late destination register
- `late_data`  in  WORD  late result
- `write`  out  1  register file write enable, registered
- `address_dest`  out  bits  registered write address
- `write_data`  out  WORD  registered write data
- `wb_stall`  out  1  FIFO full; hazard unit freezes issue

## Operation
- State machine `IDLE` / `DRAIN`:
  - `IDLE`: FIFO empty.
  - `DRAIN`: FIFO non-empty.
  - IDLE→DRAIN on any push. DRAIN→IDLE when a pop leaves the FIFO empty with no simultaneous push.
- Per-cycle selection, highest priority first:
  1. `wb_valid` with `wb_dest`≠0: issue the pipeline write.
  2. FIFO non-empty: pop the head and issue it.
  3. Otherwise `write`=0.
- Writes to $0 are consumed but never issued:
  - A pipeline write to $0 does not block a FIFO pop.
  - A late result to $0 is accepted and dropped, not pushed.
- Push when `late_valid && late_ready`. Push and pop may occur in the same cycle; count is unchanged.
- `late_ready` and `wb_stall` derive from the registered count only. A full FIFO that is popping still refuses a push that cycle.
- Load formatting (with `WB_LOAD_EXT_EN`):
  - Byte: select lane `wb_offset`.
  - Half: select lane `wb_offset[1]`.
  - Extend to 32 bits: sign-extend if `wb_signed`, else zero-extend.
  - Word: pass `wb_load` unchanged.
- Ordering: late results leave in arrival order. Pipeline and late writes to the same register resolve by issue order; the hazard unit guarantees no WAW conflict.

## Timing
- Reset: `write`=0, `address_dest`=0, `write_data`=0, `late_ready`=1, `wb_stall`=0, FIFO emptied, state `IDLE`.
- Pipeline latency:
  - Input in cycle N → `write` high during cycle N+1.
  - The register file captures on the negedge inside N+1.
- Late latency:
  - Minimum 1 cycle from accepted push to issue.
  - Unbounded while pipeline writes keep winning.
  - `wb_stall` bounds it: while stalled, issue sends `wb_valid`=0 after the pipeline drains.
- `wb_stall` rises the cycle after the count reaches `DEPTH` and falls the cycle after the first pop.
- Reset mid-operation: FIFO contents are discarded and no write is issued in the cycle after reset.

## Configuration
- `WB_LOAD_EXT_EN` defined: byte/half lane select and extension as above.
- Undefined:
  - `wb_size`, `wb_signed`, `wb_offset` are ignored.
  - A load writes `wb_load` unchanged, since the core supports only `lw`.

## Structure
- Shared package / `definitions.vh`: `WORD`, `CLOG2`, load-size encodings (`LS_BYTE`, `LS_HALF`, `LS_WORD`), state encodings.
- One sub-module: `late_fifo`, a parameterized synchronous FIFO with `push`/`pop`/`full`/`empty`/`count`.
- Load formatting stays inline as combinational logic.

## Test plan
- Pipeline only:
  - `wb_valid`, dest 5, `wb_alu`=0x1234 → next cycle `write`=1, `address_dest`=5, `write_data`=0x00001234.
  - Load byte, `wb_load`=0x80FF7F01, offset 3, signed → `write_data`=0xFFFFFF80.
  - Same load unsigned → 0x00000080.
- Collision: late push (dest 9, 0xAAAA) in the same cycle as pipeline dest 3 → dest 3 issued N+1, dest 9 issued N+2.
- Fill: three late offers back-to-back with `wb_valid` held high to nonzero dests:
  - Two accepted; `late_ready`=0 and `wb_stall`=1.
  - Third accepted only after `wb_valid` drops and a pop occurs.
- $0 handling:
  - Pipeline write to $0 alongside a non-empty FIFO → FIFO head issued.
  - Late result to $0 → accepted, never written, count unchanged.
- Reset with 2 entries queued → all outputs at reset values next cycle, `late_ready`=1, no stale write ever issued.

Source files
------------

// File: rtl/regfile_writer_pkg.sv
// Shared definitions for the register-file writeback driver: word width,
// address-width helper, load-size encodings and the drain FSM states.
package regfile_writer_pkg;

  localparam int unsigned WORD = 32;

  // Load size encodings carried on wb_size (1x = word)
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,   // late-result FIFO empty
    S_DRAIN = 1'b1    // late-result FIFO holds at least one entry
  } wb_state_t;

  // Ceiling log2, minimum 1 so it can always size a bus
  function automatic int unsigned CLOG2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/regfile_writer_late_fifo.sv
// late_fifo: parameterized synchronous FIFO holding late mul/div results.
// Head data is presented combinationally on dout; push while full and pop
// while empty are ignored. DEPTH must be a power of two (pointers wrap).
module late_fifo
  import regfile_writer_pkg::*;
#(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [CLOG2(DEPTH):0]  count
);

  localparam int unsigned AW = CLOG2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: merges the in-order MEM/WB result and late mul/div results
// onto the register file's single registered write port. Pipeline writes win;
// late results queue in late_fifo and wb_stall is raised while it is full.
// Optional feature macro: WB_LOAD_EXT_EN enables byte/half lane select and
// sign/zero extension of loads; without it loads pass wb_load unchanged.
module regfile_writer
  import regfile_writer_pkg::*;
#(
  parameter  int unsigned SIZE  = 32,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned bits  = CLOG2(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [bits-1:0]  wb_dest,
  input  logic             wb_mem_to_reg,
  input  logic [WORD-1:0]  wb_alu,
  input  logic [WORD-1:0]  wb_load,
  input  logic [1:0]       wb_size,
  input  logic             wb_signed,
  input  logic [1:0]       wb_offset,
  input  logic             late_valid,
  output logic             late_ready,
  input  logic [bits-1:0]  late_dest,
  input  logic [WORD-1:0]  late_data,
  output logic             write,
  output logic [bits-1:0]  address_dest,
  output logic [WORD-1:0]  write_data,
  output logic             wb_stall
);

  localparam int unsigned ENTRY_W = bits + WORD;
  localparam int unsigned CW      = CLOG2(DEPTH) + 1;

  wb_state_t            state;
  wb_state_t            state_next;
  logic                 pipe_issue;
  logic                 head_valid;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [ENTRY_W-1:0]   fifo_head;
  logic [WORD-1:0]      load_data;
  logic [WORD-1:0]      pipe_data;

  // Handshake and stall come from the registered count only, so a full FIFO
  // that pops this cycle still refuses the offered result.
  assign late_ready = !fifo_full;
  assign wb_stall   = fifo_full;

  late_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_late_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({late_dest, late_data}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Lane select and extension of sub-word loads
  always_comb begin
    load_byte = '0;
    load_half = '0;
    load_data = wb_load;
    case (wb_offset)
      2'd0:    load_byte = wb_load[7:0];
      2'd1:    load_byte = wb_load[15:8];
      2'd2:    load_byte = wb_load[23:16];
      default: load_byte = wb_load[31:24];
    endcase
    load_half = wb_offset[1] ? wb_load[31:16] : wb_load[15:0];
    case (wb_size)
      LS_BYTE: load_data = {{(WORD-8){wb_signed & load_byte[7]}}, load_byte};
      LS_HALF: load_data = {{(WORD-16){wb_signed & load_half[15]}}, load_half};
      default: load_data = wb_load;
    endcase
  end
`else
  logic unused_load_cfg;

  // Word-only core: loads are written exactly as read
  always_comb begin
    load_data       = wb_load;
    unused_load_cfg = ^{wb_size, wb_signed, wb_offset};
  end
`endif

  // Source selection: pipeline first, then FIFO head; $0 is never issued
  always_comb begin
    pipe_issue = wb_valid && (wb_dest != '0);
    head_valid = (state == S_DRAIN) && !fifo_empty;
    fifo_pop   = head_valid && !pipe_issue;
    fifo_push  = late_valid && late_ready && (late_dest != '0);
    pipe_data  = wb_mem_to_reg ? load_data : wb_alu;
  end

  // Next-state logic tracking FIFO occupancy
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (fifo_push) state_next = S_DRAIN;
      S_DRAIN: if (fifo_pop && !fifo_push && fifo_count == CW'(1)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Registered write port; address/data hold their last value when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      write        <= 1'b0;
      address_dest <= '0;
      write_data   <= '0;
    end else begin
      write <= pipe_issue || fifo_pop;
      if (pipe_issue) begin
        address_dest <= wb_dest;
        write_data   <= pipe_data;
      end else if (fifo_pop) begin
        address_dest <= fifo_head[ENTRY_W-1:WORD];
        write_data   <= fifo_head[WORD-1:0];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Scoreboard bench for regfile_writer. The driver issues one cycle of stimulus
// per step and pushes the expected register-file write (dest, data, cycle)
// into a queue using a queue-based reference model; an independent monitor
// pops and compares whenever the DUT asserts write.
module tb_regfile_writer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic        wb_mem_to_reg = 1'b0;
  logic [31:0] wb_alu = '0;
  logic [31:0] wb_load = '0;
  logic [1:0]  wb_size = '0;
  logic        wb_signed = 1'b0;
  logic [1:0]  wb_offset = '0;
  logic        late_valid = 1'b0;
  logic        late_ready;
  logic [4:0]  late_dest = '0;
  logic [31:0] late_data = '0;
  logic        write;
  logic [4:0]  address_dest;
  logic [31:0] write_data;
  logic        wb_stall;

  always #5 clk = ~clk;

  regfile_writer #(.SIZE(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_dest       (wb_dest),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_alu        (wb_alu),
    .wb_load       (wb_load),
    .wb_size       (wb_size),
    .wb_signed     (wb_signed),
    .wb_offset     (wb_offset),
    .late_valid    (late_valid),
    .late_ready    (late_ready),
    .late_dest     (late_dest),
    .late_data     (late_data),
    .write         (write),
    .address_dest  (address_dest),
    .write_data    (write_data),
    .wb_stall      (wb_stall)
  );

  typedef struct {
    logic        v;
    logic [4:0]  dest;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [1:0]  sz;
    logic        sg;
    logic [1:0]  off;
    logic        lv;
    logic [4:0]  ldest;
    logic [31:0] ldata;
  } stim_t;

  typedef struct { logic [4:0] dest; logic [31:0] data; } late_t;
  typedef struct { logic [4:0] dest; logic [31:0] data; int unsigned cyc; } exp_t;

  late_t       model_q[$];
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected register value of a load, from the architectural load rules
  function automatic logic [31:0] fmt_load(logic [31:0] w, logic [1:0] sz, logic sg, logic [1:0] off);
`ifdef WB_LOAD_EXT_EN
    int unsigned width;
    int unsigned shift;
    logic [31:0] mask;
    logic [31:0] v;
    if (sz[1]) return w;
    width = (sz == 2'b00) ? 8 : 16;
    shift = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
    mask  = (32'd1 << width) - 32'd1;
    v     = (w >> shift) & mask;
    if (sg && v[width-1]) v = v | ~mask;
    return v;
`else
    return w;
`endif
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.v = 1'b0; s.dest = '0; s.m2r = 1'b0; s.alu = '0; s.ld = '0;
    s.sz = '0; s.sg = 1'b0; s.off = '0; s.lv = 1'b0; s.ldest = '0; s.ldata = '0;
    return s;
  endfunction

  // One cycle of stimulus plus the reference model update
  task automatic step(input stim_t s, output bit acc);
    bit    ready;
    late_t h;
    exp_t  e;
    @(negedge clk);
    ready = (model_q.size() < DEPTH);
    check("late_ready", late_ready, ready);
    check("wb_stall", wb_stall, !ready);
    wb_valid = s.v; wb_dest = s.dest; wb_mem_to_reg = s.m2r; wb_alu = s.alu;
    wb_load = s.ld; wb_size = s.sz; wb_signed = s.sg; wb_offset = s.off;
    late_valid = s.lv; late_dest = s.ldest; late_data = s.ldata;
    acc = s.lv && ready;
    if (s.v && s.dest != 0) begin
      e.dest = s.dest;
      e.data = s.m2r ? fmt_load(s.ld, s.sz, s.sg, s.off) : s.alu;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end else if (model_q.size() != 0) begin
      h = model_q.pop_front();
      e.dest = h.dest; e.data = h.data; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    if (acc && s.ldest != 0) begin
      h.dest = s.ldest; h.data = s.ldata;
      model_q.push_back(h);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; wb_valid = 1'b0; late_valid = 1'b0;
    model_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("rst_write", write, 1'b0);
    check("rst_address_dest", address_dest, 5'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_late_ready", late_ready, 1'b1);
    check("rst_wb_stall", wb_stall, 1'b0);
  endtask

  task automatic idle_steps(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(idle(), acc);
  endtask

  // Monitor: every DUT write must match the head of the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {address_dest, write_data}, 37'd0);
        if ({address_dest, write_data} === 37'd0) begin
          n_fail++;
          $display("FAIL unexpected_write: got write=1 expected write=0 (cycle %0d)", cyc);
        end
      end else begin
        e = exp_q.pop_front();
        check("write_dest_data", {address_dest, write_data}, {e.dest, e.data});
        check("write_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check("write_missing", write, 1'b1);
    end
  end

  initial begin
    stim_t s;
    bit    acc;

    apply_reset();

    // ALU writeback
    s = idle(); s.v = 1; s.dest = 5; s.alu = 32'h1234;
    step(s, acc);
    // Byte loads at offset 3, signed then unsigned, plus half and word forms
    s = idle(); s.v = 1; s.dest = 6; s.m2r = 1; s.ld = 32'h80FF7F01;
    s.sz = 2'b00; s.sg = 1; s.off = 2'd3;
    step(s, acc);
    s.sg = 0; step(s, acc);
    s.sz = 2'b01; s.sg = 1; s.off = 2'd2; step(s, acc);
    s.off = 2'd0; step(s, acc);
    s.sz = 2'b10; step(s, acc);
    idle_steps(2);

    // Collision: pipeline dest 3 and late dest 9 in the same cycle
    s = idle(); s.v = 1; s.dest = 3; s.alu = 32'h3333;
    s.lv = 1; s.ldest = 9; s.ldata = 32'hAAAA;
    step(s, acc);
    idle_steps(3);

    // Fill with pipeline held busy, then hold a third offer until taken
    s = idle(); s.v = 1;
    for (int i = 0; i < 2; i++) begin
      s.dest = 5'(10 + i); s.alu = $urandom;
      s.lv = 1; s.ldest = 5'(20 + i); s.ldata = $urandom;
      step(s, acc);
    end
    s.ldest = 22; s.ldata = 32'hC0FFEE22;
    for (int i = 0; i < 3; i++) begin
      s.dest = 5'(13 + i); s.alu = $urandom;
      step(s, acc);
    end
    s.v = 0;
    acc = 0;
    for (int i = 0; i < 4 && !acc; i++) step(s, acc);
    idle_steps(4);

    // $0 pipeline write must not block a pop; late $0 is swallowed
    s = idle(); s.v = 1; s.dest = 4; s.alu = 32'h44;
    s.lv = 1; s.ldest = 7; s.ldata = 32'h7777;
    step(s, acc);
    s = idle(); s.v = 1; s.dest = 0; s.alu = 32'hDEAD;
    step(s, acc);
    s = idle(); s.lv = 1; s.ldest = 0; s.ldata = 32'hBAD0;
    step(s, acc);
    idle_steps(3);

    // Reset with two entries queued: nothing stale may appear afterwards
    s = idle(); s.v = 1;
    for (int i = 0; i < 2; i++) begin
      s.dest = 5'(1 + i); s.alu = $urandom;
      s.lv = 1; s.ldest = 5'(25 + i); s.ldata = $urandom;
      step(s, acc);
    end
    apply_reset();
    idle_steps(4);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        s = idle();
        s.v     = ($urandom_range(0, 99) < 60);
        s.dest  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s.m2r   = $urandom_range(0, 1);
        s.alu   = $urandom;
        s.ld    = $urandom;
        s.sz    = 2'($urandom_range(0, 3));
        s.sg    = $urandom_range(0, 1);
        s.off   = 2'($urandom_range(0, 3));
        s.lv    = ($urandom_range(0, 99) < 45);
        s.ldest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s.ldata = $urandom;
        step(s, acc);
      end
    end

    idle_steps(6);
    check("drain_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
